// File: rtl/param_register_file.sv
`default_nettype none
// ============================================================================
// Module      : param_register_file
// Description : Parameterised register file with NUM_RD combinational read
//               ports, one write port and a hardware clear sequencer. The
//               sequencer zeroes one entry per cycle, so no initial block is
//               needed for the array. Optional macro RF_WRITE_BYPASS_EN
//               forwards accepted write data to matching read ports within
//               the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module param_register_file #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,   // must be at least 1
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        write_register,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     clear_req,
    input  logic [NUM_RD*ADDR_W-1:0] read_register,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic                     busy
);

    localparam int                DEPTH       = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rf_q [DEPTH];

    logic              w_wr_accept;
    logic              w_rf_we;
    logic [ADDR_W-1:0] w_rf_waddr;
    logic [DATA_W-1:0] w_rf_wdata;

    assign busy = (state_q == ST_CLEAR);

    // A user write is only honoured in IDLE with no clear pending and no reset.
    assign w_wr_accept = RegWrite && (state_q == ST_IDLE) && !clear_req && !reset;

    // Next-state logic: clear_req starts a sweep from 0, the sweep ends on the last address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == C_LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // State and sweep counter; reset always (re)starts the sweep at address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array write port arbitration: the clear sweep owns the port while busy.
    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_waddr = write_register;
        w_rf_wdata = write_data;
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                w_rf_we    = 1'b1;
                w_rf_waddr = cnt_q;
                w_rf_wdata = '0;
            end else if (w_wr_accept && !((ZERO_REG != 0) && (write_register == '0))) begin
                w_rf_we = 1'b1;
            end
        end
    end

    // Storage array; deliberately not reset, the clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (w_rf_we) begin
            rf_q[w_rf_waddr] <= w_rf_wdata;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_lane;

        assign w_addr = read_register[k*ADDR_W +: ADDR_W];

        // Read lane: array value, optional write forwarding, then busy/zero-reg masking.
        always_comb begin
            w_lane = rf_q[w_addr];
`ifdef RF_WRITE_BYPASS_EN
            if (w_wr_accept && (w_addr == write_register)) begin
                w_lane = write_data;
            end
`endif
            if (busy || ((ZERO_REG != 0) && (w_addr == '0))) begin
                w_lane = '0;
            end
        end

        assign read_data[k*DATA_W +: DATA_W] = w_lane;
    end

endmodule
`default_nettype wire

// File: tb/tb_param_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_register_file
// Description : Self-checking bench for param_register_file. A default
//               instance and a ZERO_REG=1 instance share all inputs.
//               Expected read-during-write results follow RF_WRITE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_register_file;

`ifdef RF_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [3:0]  write_register;
    logic [15:0] write_data;
    logic        clear_req;
    logic [3:0]  r0, r1;
    logic [7:0]  read_register;
    logic [31:0] read_data, read_data_z;
    logic        busy, busy_z;

    int n_checks = 0;
    int n_fail   = 0;

    assign read_register = {r1, r0};

    always #5 clk = ~clk;

    param_register_file dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .write_register(write_register), .write_data(write_data),
        .clear_req(clear_req), .read_register(read_register),
        .read_data(read_data), .busy(busy)
    );

    param_register_file #(.ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .write_register(write_register), .write_data(write_data),
        .clear_req(clear_req), .read_register(read_register),
        .read_data(read_data_z), .busy(busy_z)
    );

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        clr;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] ez0;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Counts busy cycles (bounded) and confirms every read lane stays zero meanwhile.
    task automatic wait_clear(input string name);
        int n     = 0;
        bit rd_ok = 1'b1;
        while (busy === 1'b1 && n < 100) begin
            if (read_data !== 32'h0 || read_data_z !== 32'h0) rd_ok = 1'b0;
            n++;
            tick();
        end
        check({name, " busy cycles"}, n, 16);
        check({name, " reads zero while busy"}, {31'h0, rd_ok}, 32'h1);
    endtask

    initial begin
        // we  wa    wd        clr  ra0   ra1   e0                        e1                        ez0
        vecs[0] = '{1'b1, 4'd5, 16'hABCD, 1'b0, 4'd1, 4'd2, 16'h0000, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd5, 4'd5, 16'hABCD, 16'hABCD, 16'hABCD};
        vecs[2] = '{1'b1, 4'd9, 16'h0001, 1'b0, 4'd5, 4'd0, 16'hABCD, 16'h0000, 16'hABCD};
        vecs[3] = '{1'b1, 4'd9, 16'h00FF, 1'b0, 4'd9, 4'd9,
                    BYP ? 16'h00FF : 16'h0001, BYP ? 16'h00FF : 16'h0001, BYP ? 16'h00FF : 16'h0001};
        vecs[4] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd9, 4'd5, 16'h00FF, 16'hABCD, 16'h00FF};
        vecs[5] = '{1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd1, 4'd2, 16'h0000, 16'h0000, 16'h0000};
        vecs[6] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[7] = '{1'b1, 4'd3, 16'h1234, 1'b1, 4'd3, 4'd0, 16'h0000, 16'hFFFF, 16'h0000};

        reset = 1'b1; RegWrite = 1'b0; write_register = '0; write_data = '0;
        clear_req = 1'b0; r0 = 4'd5; r1 = 4'd5;

        // One-cycle reset, then a full 16-cycle sweep.
        tick();
        reset = 1'b0;
        check("busy after reset", {31'h0, busy}, 32'h1);
        check("read_data after reset", read_data, 32'h0);
        wait_clear("post-reset clear");
        for (int a = 0; a < 16; a++) begin
            r0 = 4'(a); r1 = 4'(15 - a);
            #1;
            check($sformatf("reg %0d/%0d zero after clear", a, 15 - a), read_data, 32'h0);
        end

        // Table: inputs applied before the edge, outputs checked pre-edge.
        for (int i = 0; i < 8; i++) begin
            RegWrite = vecs[i].we; write_register = vecs[i].wa; write_data = vecs[i].wd;
            clear_req = vecs[i].clr; r0 = vecs[i].ra0; r1 = vecs[i].ra1;
            #1;
            check($sformatf("vec%0d lane0", i), {16'h0, read_data[15:0]}, {16'h0, vecs[i].e0});
            check($sformatf("vec%0d lane1", i), {16'h0, read_data[31:16]}, {16'h0, vecs[i].e1});
            check($sformatf("vec%0d zreg lane0", i), {16'h0, read_data_z[15:0]}, {16'h0, vecs[i].ez0});
            check($sformatf("vec%0d busy", i), {31'h0, busy}, 32'h0);
            tick();
        end

        // vec7 started a clear; writes and further clear requests are ignored meanwhile.
        RegWrite = 1'b1; write_register = 4'd7; write_data = 16'h7777; clear_req = 1'b1;
        wait_clear("clear_req sweep");
        RegWrite = 1'b0; clear_req = 1'b0;
        r0 = 4'd3; r1 = 4'd7;
        #1;
        check("reg3 dropped write", {16'h0, read_data[15:0]}, 32'h0);
        check("reg7 write during busy", {16'h0, read_data[31:16]}, 32'h0);
        r0 = 4'd9; r1 = 4'd5;
        #1;
        check("reg9/reg5 cleared", read_data, 32'h0);

        // Reset mid-sweep at counter 7 restarts the full sweep.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        check("busy before mid reset", {31'h0, busy}, 32'h1);
        reset = 1'b1; RegWrite = 1'b1; write_register = 4'd4; write_data = 16'h4444;
        tick();
        reset = 1'b0; RegWrite = 1'b0;
        wait_clear("restart after mid reset");

        // Normal write works again, and the reset-cycle write did not land.
        RegWrite = 1'b1; write_register = 4'd2; write_data = 16'h5A5A;
        tick();
        RegWrite = 1'b0; r0 = 4'd2; r1 = 4'd4;
        #1;
        check("reg2 after restart", {16'h0, read_data[15:0]}, 32'h5A5A);
        check("reg4 reset-cycle write", {16'h0, read_data[31:16]}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of each register in bits.
REQ-002 SHALL have parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter NUM_RD, default 2: number of independent read ports, minimum 1.
REQ-004 SHALL have parameter ZERO_REG, default 0: when 1, register 0 always reads 0 and ignores writes.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port RegWrite, input, 1 bit: write enable.
REQ-008 SHALL have port write_register, input, ADDR_W bits: write address.
REQ-009 SHALL have port write_data, input, DATA_W bits: write data.
REQ-010 SHALL have port clear_req, input, 1 bit: one-cycle request to zero the whole array.
REQ-011 SHALL have port read_register, input, NUM_RD*ADDR_W bits: packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-012 SHALL have port read_data, output, NUM_RD*DATA_W bits: packed read data; port k uses bits [k*DATA_W +: DATA_W].
REQ-013 SHALL have port busy, output, 1 bit: high while the clear sequence runs.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-015 SHALL hold a clear counter of ADDR_W bits; in CLEAR, each cycle writes 0 to rf[counter] and increments the counter.
REQ-016 SHALL move from CLEAR to IDLE on the edge that clears address DEPTH-1, so a full clear takes exactly DEPTH cycles.
REQ-017 SHALL enter CLEAR with counter 0 from IDLE when clear_req=1.
REQ-018 SHALL drive busy as a decode of state, equal to 1 exactly when the FSM is in CLEAR.
REQ-019 SHALL ignore clear_req while in CLEAR; the counter does not restart.
REQ-020 SHALL write write_data to rf[write_register] on the edge when RegWrite=1, state is IDLE, and clear_req=0.
REQ-021 SHALL give clear_req priority over RegWrite in the same IDLE cycle; that write is dropped.
REQ-022 SHALL drop all writes while busy=1; no write queueing.
REQ-023 SHALL make reads combinational: zero latency, and each port independent, with all ports allowed to address the same register.
REQ-024 SHALL force every read_data lane to 0 while busy=1.
REQ-025 SHALL, with ZERO_REG=1, return 0 from any read of address 0 and discard writes to address 0.

Reset
REQ-026 SHALL, on a clk edge with reset=1, set state to CLEAR and counter to 0, so busy=1 and read_data=0 from the next cycle.
REQ-027 SHALL run the clear sequence after reset deasserts, leaving all registers 0 after DEPTH further cycles; the array needs no initial block.
REQ-028 SHALL restart the clear sequence at counter 0 if reset is asserted mid-clear.
REQ-029 SHALL give reset priority over clear_req and RegWrite.

Configuration
REQ-030 SHALL use macro RF_WRITE_BYPASS_EN to select read-during-write behaviour.
REQ-031 SHALL, with RF_WRITE_BYPASS_EN defined, return write_data combinationally on any read port whose address matches write_register while an accepted write (REQ-020) is present; ZERO_REG and busy masking still apply.
REQ-032 SHALL, without RF_WRITE_BYPASS_EN, return the old stored value in that case until after the edge.

Verification
REQ-033 SHALL cover: reset for 1 cycle with defaults -> busy=1 for exactly 16 cycles after release, read_data=0 throughout, and all registers read 0 after busy falls.
REQ-034 SHALL cover: write 16'hABCD to reg 5, then read ports 0 and 1 both at 5 -> both lanes 16'hABCD the cycle after the write.
REQ-035 SHALL cover: RegWrite=1 to reg 3 with data 16'h1234 and clear_req=1 in the same cycle -> write dropped, and reg 3 reads 0 after the 16-cycle clear.
REQ-036 SHALL cover: reset asserted at clear counter 7 -> counter restarts at 0 and busy stays high for 16 cycles after release.
REQ-037 SHALL cover: with RF_WRITE_BYPASS_EN, reg 9 holds 16'h0001, write 16'h00FF to reg 9 and read reg 9 in the same cycle -> 16'h00FF; without the macro -> 16'h0001.
REQ-038 SHALL cover: ZERO_REG=1, write 16'hFFFF to reg 0 -> read of reg 0 returns 0.
